// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int unsigned MD_ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    // Multiply: multiplier sits in the low half and is consumed LSB first.
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    trial   = shifted - {1'b0, operand};
    if (div_mode) begin
      if (trial[WIDTH]) begin
        acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and single-cycle MTHI/MTLO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  md_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic                 dz_q, dz_d;
  logic                 done_q, done_d;

  logic                 sgn_op, div_op, md_op;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  assign sgn_op = (mdOp == MD_MULT) || (mdOp == MD_DIV);
  assign div_op = (mdOp == MD_DIV) || (mdOp == MD_DIVU);
  assign md_op  = sgn_op || div_op || (mdOp == MD_MULTU);
  assign abs_a  = (sgn_op && busA[WIDTH-1]) ? -busA : busA;
  assign abs_b  = (sgn_op && busB[WIDTH-1]) ? -busB : busB;

  assign prod = neg_q_q ? -acc_q : acc_q;
  assign quo  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode(is_div_q),
    .acc_in  (acc_q),
    .operand (opb_q),
    .acc_out (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && md_op) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = div_op;
          neg_q_d  = sgn_op && (busA[WIDTH-1] ^ busB[WIDTH-1]);
          neg_r_d  = sgn_op && div_op && busA[WIDTH-1];
          dz_d     = (busB == '0);
          acc_d    = {{WIDTH{1'b0}}, (div_op ? abs_a : abs_b)};
          opb_d    = div_op ? abs_b : abs_a;
        end else if (start && (mdOp == MD_MTHI)) begin
          hi_d = busA;
        end else if (start && (mdOp == MD_MTLO)) begin
          lo_d = busA;
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Remainder already equals busA on divide-by-zero; only the quotient needs forcing.
          lo_d = dz_q ? '1 : quo;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against a longint arithmetic reference.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] busA, busB;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural HI/LO as the bench expects them
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mdOp (mdOp),
    .busA (busA),
    .busB (busB),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     q, r, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      3'b000: res = sa * sb;
      3'b001: res = ua * ub;
      3'b010, 3'b011: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          if (op == 3'b010) begin
            sq = sa / sb;
            sr = sa % sb;
            q  = sq;
            r  = sr;
          end else begin
            q = ua / ub;
            r = ua % ub;
          end
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  // Mult/div transaction; optionally pokes MTHI 0x1234 at CALC cycle inj_cyc.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj_cyc);
    logic [63:0] exp;
    logic [31:0] hold_hi, hold_lo;
    bit          bad;
    exp     = ref_md(op, a, b);
    hold_hi = m_hi;
    hold_lo = m_lo;
    start = 1'b1;
    mdOp  = op;
    busA  = a;
    busB  = b;
    tick();  // E0
    start = 1'b0;
    busA  = $urandom;
    busB  = $urandom;
    check_eq({tag, " busy after start"}, {62'b0, busy, done}, 64'b10);
    bad = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (c == inj_cyc) begin
        start = 1'b1;
        mdOp  = 3'b100;
        busA  = 32'h1234;
      end
      tick();  // E_c
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0 || hi !== hold_hi || lo !== hold_lo) bad = 1'b1;
    end
    check_eq({tag, " busy window"}, {63'b0, bad}, 64'b0);
    tick();  // E33
    check_eq({tag, " done after fix"}, {62'b0, busy, done}, 64'b01);
    check_eq({tag, " hilo"}, {hi, lo}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    tick();  // E34
    check_eq({tag, " done pulse"}, {62'b0, busy, done}, 64'b00);
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    start = 1'b1;
    mdOp  = op;
    busA  = a;
    tick();
    start = 1'b0;
    if (op == 3'b100) m_hi = a;
    if (op == 3'b101) m_lo = a;
    check_eq({tag, " hilo"}, {hi, lo}, {m_hi, m_lo});
    check_eq({tag, " flags"}, {62'b0, busy, done}, 64'b00);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst   = 1'b1;
    start = 1'b0;
    mdOp  = '0;
    busA  = '0;
    busB  = '0;
    #12;
    check_eq("reset hilo", {hi, lo}, 64'b0);
    check_eq("reset flags", {62'b0, busy, done}, 64'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_md("mult 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    run_md("multu max*max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_md("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 0);
    run_md("divu 7/0", 3'b011, 32'd7, 32'd0, 0);
    run_md("div overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md("div -9/0", 3'b010, 32'hFFFF_FFF7, 32'd0, 0);
    run_md("mult busy mthi", 3'b000, 32'h0001_2345, 32'hFFFF_0003, 5);
    run_mt("mtlo idle", 3'b101, 32'h0000_ABCD);
    run_mt("noop 110", 3'b110, 32'h5555_5555);

    // Abort a DIVU with asynchronous reset partway through CALC
    start = 1'b1;
    mdOp  = 3'b011;
    busA  = 32'd100;
    busB  = 32'd7;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check_eq("rst abort hilo", {hi, lo}, 64'b0);
    check_eq("rst abort flags", {62'b0, busy, done}, 64'b0);
    m_hi = '0;
    m_lo = '0;
    #1;
    rst = 1'b0;
    tick();
    check_eq("post rst idle", {62'b0, busy, done}, 64'b0);
    run_md("multu 3*5", 3'b001, 32'd3, 32'd5, 0);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      if (op[2]) run_mt("rand mt", op, a);
      else       run_md("rand md", op, a, b, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
